// File: rtl/mb_pkg.sv
// mb_pkg: shared types, drain states and the odd-parity helper for the MB word buffer.
package mb_pkg;
   typedef logic [35:0] mb_word_t;
   typedef logic [1:0] mb_idx_t;
   typedef enum logic [1:0] {MB_IDLE, MB_SEND, MB_DONE} mb_state_t;
   function automatic logic mb_odd_par(input mb_word_t word, input logic par);
      return ^{word, par};
   endfunction
endpackage

// File: rtl/mb_next_word.sv
// mb_next_word: rotating-priority search for the first set valid bit at or after start.
module mb_next_word
   import mb_pkg::*;
(
   input  logic [3:0] valid,
   input  mb_idx_t    start,
   output logic       found,
   output mb_idx_t    idx
);
   always_comb begin
      found = 1'b0;
      idx = start;
      for (int i = 3; i >= 0; i--) begin
         if (valid[start + mb_idx_t'(i)]) begin
            found = 1'b1;
            idx = start + mb_idx_t'(i);
         end
      end
   end
endmodule

// File: rtl/mb_word_buffer.sv
// mb_word_buffer: four-word MB buffer that drains valid words to SBUS memory in quadword wrap order.
module mb_word_buffer
   import mb_pkg::*;
#(
   parameter int WIDTH = 36
) (
   input  logic             clk1_mb_h,
   input  logic             mr_reset_h,
   input  logic [WIDTH-1:0] mb_in_h,
   input  logic             mb_par_bit_in_h,
   input  logic [3:0]       mb_hold_in_h,
   input  logic             mb_drain_start_h,
   input  logic [1:0]       drain_adr_h,
   input  logic             ackn_pulse_h,
   output logic [WIDTH-1:0] mem_data_h,
   output logic             mem_par_h,
   output logic [1:0]       mb_sel_h,
   output logic             mem_wr_rq_h,
   output logic [3:0]       mb_valid_h,
   output logic             mb_busy_h,
   output logic             mb_done_h,
   output logic             mb_par_err_h,
   input  logic             mb_par_err_clr_h
);
   logic [WIDTH-1:0] data_q [4];
   logic [3:0]       par_q;
   mb_state_t        state;
   mb_idx_t          sel, nxt;
   logic [3:0]       valid, valid_n, load, ack_clr;
   logic             sending, ack, bad, found, par_err;
   assign sending = state == MB_SEND;
   assign ack     = sending && ackn_pulse_h;
   // The word under the memory is frozen while it is being presented.
   assign load    = mb_hold_in_h & ~(sending ? 4'b0001 << sel : 4'b0000);
   assign ack_clr = ack ? 4'b0001 << sel : 4'b0000;
   assign valid_n = (valid & ~ack_clr) | load;
   assign bad     = ack && !mb_odd_par(data_q[sel], par_q[sel]);
   mb_next_word u_next (
      .valid(state == MB_IDLE ? valid : valid_n),
      .start(state == MB_IDLE ? drain_adr_h : sel + 2'd1),
      .found(found),
      .idx  (nxt)
   );
   always_ff @(posedge clk1_mb_h) begin
      if (mr_reset_h) begin
         state   <= MB_IDLE;
         sel     <= '0;
         valid   <= '0;
         par_err <= 1'b0;
      end else begin
         valid   <= valid_n;
         par_err <= bad | (par_err & ~mb_par_err_clr_h);
         if ((state == MB_IDLE && mb_drain_start_h) || ack) begin
            state <= found ? MB_SEND : MB_DONE;
            sel   <= found ? nxt : sel;
         end else if (state == MB_DONE) begin
            state <= MB_IDLE;
         end
      end
   end
   always_ff @(posedge clk1_mb_h) begin
      for (int n = 0; n < 4; n++) begin
         if (load[n]) begin
            data_q[n] <= mb_in_h;
            par_q[n]  <= mb_par_bit_in_h;
         end
      end
   end
   assign mem_data_h   = data_q[sel];
   assign mem_par_h    = par_q[sel];
   assign mb_sel_h     = sel;
   assign mem_wr_rq_h  = sending;
   assign mb_valid_h   = valid;
   assign mb_busy_h    = state != MB_IDLE;
   assign mb_done_h    = state == MB_DONE;
   assign mb_par_err_h = par_err;
endmodule

// File: tb/tb_mb_word_buffer.sv
// tb_mb_word_buffer: scoreboard bench with a word-list reference model of the MB drain order.
module tb_mb_word_buffer;
   typedef struct {
      bit          done;
      logic [1:0]  sel;
      logic [35:0] d;
      logic        p;
   } exp_t;

   logic        clk = 0, rst = 1;
   logic [35:0] mb_in = '0;
   logic        par_in = 0, start = 0, ack = 0, clr = 0;
   logic [3:0]  hold = '0;
   logic [1:0]  adr = '0;
   logic [35:0] mem_data;
   logic        mem_par, wr_rq, busy, done, par_err;
   logic [1:0]  sel;
   logic [3:0]  valid;

   exp_t        sb[$];
   int          pass_cnt = 0, total = 0, done_cnt = 0;
   bit          wr_seen = 0;
   logic [35:0] md [4];
   logic        mp [4];
   logic [3:0]  mv = '0;
   logic        exp_err = 0;

   mb_word_buffer dut (
      .clk1_mb_h(clk), .mr_reset_h(rst), .mb_in_h(mb_in), .mb_par_bit_in_h(par_in),
      .mb_hold_in_h(hold), .mb_drain_start_h(start), .drain_adr_h(adr), .ackn_pulse_h(ack),
      .mem_data_h(mem_data), .mem_par_h(mem_par), .mb_sel_h(sel), .mem_wr_rq_h(wr_rq),
      .mb_valid_h(valid), .mb_busy_h(busy), .mb_done_h(done), .mb_par_err_h(par_err),
      .mb_par_err_clr_h(clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic good_par(input logic [35:0] d);
      return ~^d;
   endfunction

   // Monitor: every acknowledged word and every done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (wr_rq) wr_seen = 1;
         if (wr_rq && ack) begin
            if (sb.size() == 0) chk("unexpected_word", {sel, mem_data}, '1);
            else begin
               e = sb.pop_front();
               chk("word_is_data", e.done, 0);
               chk("word_sel", sel, e.sel);
               chk("word_data", mem_data, e.d);
               chk("word_par", mem_par, e.p);
            end
         end
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", done, 0);
            else begin
               e = sb.pop_front();
               chk("done_marker", e.done, 1);
            end
         end
      end
   end

   task automatic load(input logic [3:0] mask, input logic [35:0] d, input logic p);
      hold = mask; mb_in = d; par_in = p;
      tick();
      hold = '0;
      for (int n = 0; n < 4; n++) if (mask[n]) begin md[n] = d; mp[n] = p; mv[n] = 1; end
      chk("valid_after_load", valid, mv);
   endtask

   task automatic push_drain(input logic [1:0] a);
      logic [1:0] w;
      for (int k = 0; k < 4; k++) begin
         w = a + 2'(k);
         if (mv[w]) begin
            sb.push_back('{0, w, md[w], mp[w]});
            if (^{md[w], mp[w]} != 1'b1) exp_err = 1;
            mv[w] = 0;
         end
      end
      sb.push_back('{1, 2'd0, 36'd0, 1'b0});
   endtask

   task automatic serve(input int gap);
      int n = 0;
      while (busy && n < 400) begin
         if (wr_rq) begin
            repeat (gap) tick();
            ack = 1;
            tick();
            ack = 0;
            if (!wr_rq) chk("done_after_last_ack", done, 1);
         end else tick();
         n++;
      end
      if (busy) chk("drain_timeout", busy, 0);
      chk("valid_empty", valid, 0);
   endtask

   task automatic drain(input logic [1:0] a, input int gap);
      bit empty = (mv == 0);
      push_drain(a);
      adr = a; start = 1;
      tick();
      start = 0;
      if (empty) begin
         chk("empty_done", done, 1);
         chk("empty_wr_rq", wr_rq, 0);
      end else chk("first_word_wr_rq", wr_rq, 1);
      serve(gap);
   endtask

   initial begin
      int d0;
      logic [35:0] r;
      tick(); tick();
      chk("rst_valid", valid, 0);
      chk("rst_sel", sel, 0);
      chk("rst_wr_rq", wr_rq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_par_err", par_err, 0);
      rst = 0;
      tick();

      // Four words, drain from 2, ack every 2 cycles.
      for (int n = 0; n < 4; n++) load(4'b0001 << n, 36'(n + 1), good_par(36'(n + 1)));
      d0 = done_cnt;
      drain(2'd2, 1);
      chk("done_once", done_cnt - d0, 1);
      tick();
      chk("idle_after_done", busy, 0);

      // Sparse valid 1010 from 0.
      load(4'b1010, 36'h5a5a5a5a5, good_par(36'h5a5a5a5a5));
      drain(2'd0, 0);

      // Empty drain.
      wr_seen = 0;
      drain(2'd3, 0);
      chk("empty_never_wr_rq", wr_seen, 0);

      // Bad parity on MB2, sticky until clear.
      load(4'b0100, 36'd0, 1'b0);
      load(4'b0001, 36'h123, good_par(36'h123));
      drain(2'd0, 0);
      chk("par_err_set", par_err, exp_err);
      repeat (3) tick();
      chk("par_err_sticky", par_err, 1);
      clr = 1; tick(); clr = 0; exp_err = 0;
      chk("par_err_cleared", par_err, 0);

      // Loads while presenting MB1.
      load(4'b0010, 36'hAAA, good_par(36'hAAA));
      sb.push_back('{0, 2'd1, 36'hAAA, good_par(36'hAAA)});
      mv = '0;
      adr = 2'd1; start = 1; tick(); start = 0;
      chk("sel_is_1", sel, 1);
      hold = 4'b0010; mb_in = 36'hBBB; par_in = 0;
      tick();
      hold = '0;
      chk("sel_data_frozen", mem_data, 36'hAAA);
      chk("sel_load_ignored_valid", valid, 4'b0010);
      hold = 4'b1000; mb_in = 36'hCCC; par_in = good_par(36'hCCC); ack = 1;
      md[3] = 36'hCCC; mp[3] = good_par(36'hCCC);
      sb.push_back('{0, 2'd3, 36'hCCC, good_par(36'hCCC)});
      sb.push_back('{1, 2'd0, 36'd0, 1'b0});
      tick();
      hold = '0; ack = 0;
      chk("load_ack_next_sel", sel, 3);
      chk("load_ack_next_data", mem_data, 36'hCCC);
      serve(0);

      // Reset in the middle of a 4-word drain.
      for (int n = 0; n < 4; n++) load(4'b0001 << n, 36'(n + 16), good_par(36'(n + 16)));
      sb.push_back('{0, 2'd0, md[0], mp[0]});
      adr = 2'd0; start = 1; tick(); start = 0;
      ack = 1; tick(); ack = 0;
      rst = 1; tick(); rst = 0;
      mv = '0;
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sel", sel, 0);
      chk("mid_rst_done", done, 0);
      tick();
      chk("mid_rst_no_done", done, 0);
      chk("mid_rst_sb_empty", sb.size(), 0);

      // Randomized loads and drains.
      for (int it = 0; it < 30; it++) begin
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            r = 36'({$urandom, $urandom});
            load(4'($urandom_range(0, 15)), r, ($urandom_range(0, 3) == 0) ? ~good_par(r) : good_par(r));
         end
         drain(2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         chk("rand_par_err", par_err, exp_err);
         clr = 1; tick(); clr = 0; exp_err = 0;
      end

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
